q_update_pipe: RTL and testbench
================================

// Module: q_update_pipe
// PURPOSE
//  Pipelined, parametrised Q-learning update unit:
//    Q_new = Q + 2^-a * (reward + 2^-g * max_Q - Q).
//  Signed operands; alpha and gamma are right-shift amounts. Terminal-state mode; output saturation.
//  Valid/ready streaming, throughput 1 update/cycle; an opaque tag travels alongside each update.
//  Sits between the Q-table read port/max-finder and the Q-table write port of the agent.
// PARAMETERS
//  DATA_W   16  width of Q, max_Q, reward, Q_new (signed two's complement)
//  SHIFT_W  2   width of alpha_sh/gamma_sh; shift range 0..2^SHIFT_W-1
//  TAG_W    8   width of tag (state/action index), passed through unmodified
//  SATURATE 1   1: clamp Q_new to signed DATA_W range; 0: wrap (truncate)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        unit can accept a beat this cycle
//  q_in       in   DATA_W   current Q(s,a), signed
//  max_q      in   DATA_W   max_a' Q(s',a'), signed
//  reward     in   DATA_W   immediate reward, signed
//  alpha_sh   in   SHIFT_W  learning-rate shift (alpha = 2^-alpha_sh)
//  gamma_sh   in   SHIFT_W  discount shift (gamma = 2^-gamma_sh)
//  terminal   in   1        1: s' is terminal, discounted max_q term forced to 0
//  tag_in     in   TAG_W    sideband, returned with result
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  q_out      out  DATA_W   updated Q, signed
//  tag_out    out  TAG_W    tag of this result
//  sat_out    out  1        1: q_out was clamped (always 0 when SATURATE=0)
// BEHAVIOUR
//  Reset: all stage valids = 0; out_valid=0, q_out=0, tag_out=0, sat_out=0; in_ready=1 after reset.
//  Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  Pipeline (3 register stages, latency 3 cycles accept->out_valid when not stalled):
//   S1: e1 = terminal ? 0 : (max_q >>> gamma_sh); td = reward + e1 - q_in, width DATA_W+2 signed.
//       Register td, q_in, alpha_sh, tag.
//   S2: e2 = td >>> alpha_sh (arithmetic, rounds toward -inf), width DATA_W+2. Register e2, q_in, tag.
//   S3: sum = q_in + e2, width DATA_W+3.
//       SATURATE=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1], sat=1 if clamped; else low DATA_W bits, sat=0.
//  Flow control: stage k loads when it is empty or its content leaves this cycle.
//   Output stage leaves when out_ready; in_ready = !v1 | s1 leaves. Bubbles collapse.
//  Full stall (out_ready=0, 3 beats held): in_ready=0.
//   q_out/tag_out/sat_out stay stable while out_valid & !out_ready.
//  Simultaneous accept and emit with a full pipe: both happen and occupancy is unchanged.
//  Order is preserved strictly; no beat is dropped or duplicated.
//  rst_n low at any time: pipeline contents discarded immediately (async); no partial result is emitted.
//  alpha_sh/gamma_sh are sampled per beat; a change between beats takes effect on the next accepted beat.
// STRUCTURE
//  Package q_learn_pkg: DATA_W/SHIFT_W defaults, q_sat() clamp function, QMAX/QMIN localparams.
//  Sub-module q_ashift (param W, SHIFT_W): combinational arithmetic right barrel shift.
//   Instantiated twice: gamma in S1, alpha in S2.
//  Remaining logic (stage regs, valid/ready chain, saturation) lives in q_update_pipe.
// TESTING
//  1 q=100,max=200,r=50,g=1,a=2,term=0 -> q_out=112, sat=0, out_valid 3 cycles after accept.
//  2 q=100,max=500,r=-20,a=1,term=1 -> td=-120, q_out=40 (max_q ignored).
//  3 q=32000,max=32767,r=32767,g=0,a=0 -> q_out=32767, sat=1.
//    Same beat with SATURATE=0 -> q_out=-2 (wrap), sat=0.
//  4 q=0,max=0,r=-7,a=1 -> e2=-4, q_out=-4 (floor rounding).
//  5 Stream 6 beats with out_ready low 5 cycles -> in_ready low after 3 held.
//    q_out stable while stalled; all 6 results emitted in order with matching tags.
//  6 Back-to-back 20 random beats, out_ready=1 -> one result/cycle matching reference model.
//    Assert rst_n mid-stream -> out_valid=0 at once, in_ready=1 after release, no stale output.

Source files
------------

// File: rtl/q_learn_pkg.sv
// Shared constants and saturation helper for the Q-learning update datapath.
package q_learn_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_SHIFT_W = 2;
  localparam int unsigned DEF_TAG_W   = 8;

  // Working width of the clamp helper; wide enough for any practical DATA_W.
  localparam int unsigned SAT_W = 64;

  // Signed range limits at the default data width.
  localparam logic signed [DEF_DATA_W-1:0] QMAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic signed [DEF_DATA_W-1:0] QMIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] q_sat(input logic signed [SAT_W-1:0] x,
                                                    input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 32'd1)) - SAT_W'(1);
    lo = ~hi;
    if (x > hi)      q_sat = hi;
    else if (x < lo) q_sat = lo;
    else             q_sat = x;
  endfunction

endpackage

// File: rtl/q_ashift.sv
// Combinational arithmetic right barrel shifter (floor division by 2^sh).
module q_ashift #(
  parameter int unsigned W       = 16,
  parameter int unsigned SHIFT_W = 2
) (
  input  logic signed [W-1:0]       din,
  input  logic        [SHIFT_W-1:0] sh,
  output logic signed [W-1:0]       dout_c
);

  // One conditional power-of-two stage per shift-amount bit.
  always_comb begin
    dout_c = din;
    for (int i = 0; i < int'(SHIFT_W); i++) begin
      if (sh[i]) dout_c = dout_c >>> (1 << i);
    end
  end

endmodule

// File: rtl/q_update_pipe.sv
// Three-stage Q-learning update: Q + 2^-a * (r + 2^-g * maxQ - Q), valid/ready streamed.
module q_update_pipe #(
  parameter int unsigned DATA_W   = q_learn_pkg::DEF_DATA_W,
  parameter int unsigned SHIFT_W  = q_learn_pkg::DEF_SHIFT_W,
  parameter int unsigned TAG_W    = q_learn_pkg::DEF_TAG_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  q_in,
  input  logic signed [DATA_W-1:0]  max_q,
  input  logic signed [DATA_W-1:0]  reward,
  input  logic        [SHIFT_W-1:0] alpha_sh,
  input  logic        [SHIFT_W-1:0] gamma_sh,
  input  logic                      terminal,
  input  logic        [TAG_W-1:0]   tag_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  q_out,
  output logic        [TAG_W-1:0]   tag_out,
  output logic                      sat_out
);

  import q_learn_pkg::*;

  localparam int unsigned TD_W  = DATA_W + 2;
  localparam int unsigned SUM_W = DATA_W + 3;

  // Stage 1 registers
  logic                     v1;
  logic signed [TD_W-1:0]   td1;
  logic signed [DATA_W-1:0] q1;
  logic [SHIFT_W-1:0]       a1;
  logic [TAG_W-1:0]         tag1;

  // Stage 2 registers
  logic                     v2;
  logic signed [TD_W-1:0]   e2r;
  logic signed [DATA_W-1:0] q2;
  logic [TAG_W-1:0]         tag2;

  // Combinational datapath and handshake
  logic signed [DATA_W-1:0] e1_c;
  logic signed [DATA_W-1:0] e1_term_c;
  logic signed [TD_W-1:0]   td_c;
  logic signed [TD_W-1:0]   e2_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SAT_W-1:0]  sat_c;
  logic signed [DATA_W-1:0] q_next_c;
  logic                     sat_next_c;
  logic                     ld1_c;
  logic                     ld2_c;
  logic                     ld3_c;

  q_ashift #(.W(DATA_W), .SHIFT_W(SHIFT_W)) u_gamma_shift (
    .din    (max_q),
    .sh     (gamma_sh),
    .dout_c (e1_c)
  );

  q_ashift #(.W(TD_W), .SHIFT_W(SHIFT_W)) u_alpha_shift (
    .din    (td1),
    .sh     (a1),
    .dout_c (e2_c)
  );

  // Temporal difference; terminal next-state drops the bootstrap term.
  always_comb begin
    e1_term_c = terminal ? '0 : e1_c;
    td_c      = TD_W'(reward) + TD_W'(e1_term_c) - TD_W'(q_in);
  end

  // Final sum with optional clamp to the signed output range.
  always_comb begin
    sum_c      = SUM_W'(q2) + SUM_W'(e2r);
    sat_c      = q_sat(SAT_W'(sum_c), DATA_W);
    q_next_c   = SATURATE ? DATA_W'(sat_c) : DATA_W'(sum_c);
    sat_next_c = SATURATE && (sat_c != SAT_W'(sum_c));
  end

  // A stage loads when empty or when its content moves on this cycle.
  always_comb begin
    ld3_c = !out_valid | out_ready;
    ld2_c = !v2 | ld3_c;
    ld1_c = !v1 | ld2_c;
  end

  assign in_ready = ld1_c;

  // Stage 1: capture temporal difference and side information.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      td1  <= '0;
      q1   <= '0;
      a1   <= '0;
      tag1 <= '0;
    end else if (ld1_c) begin
      v1 <= in_valid;
      if (in_valid) begin
        td1  <= td_c;
        q1   <= q_in;
        a1   <= alpha_sh;
        tag1 <= tag_in;
      end
    end
  end

  // Stage 2: learning-rate scaled error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      e2r  <= '0;
      q2   <= '0;
      tag2 <= '0;
    end else if (ld2_c) begin
      v2 <= v1;
      if (v1) begin
        e2r  <= e2_c;
        q2   <= q1;
        tag2 <= tag1;
      end
    end
  end

  // Stage 3: registered result, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q_out     <= '0;
      tag_out   <= '0;
      sat_out   <= 1'b0;
    end else if (ld3_c) begin
      out_valid <= v2;
      if (v2) begin
        q_out   <= q_next_c;
        tag_out <= tag2;
        sat_out <= sat_next_c;
      end
    end
  end

endmodule

// File: tb/tb_q_update_pipe.sv
// Randomised and directed bench for q_update_pipe, saturating and wrapping builds side by side.
module tb_q_update_pipe;
  import q_learn_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;
  localparam int unsigned TW = 8;

  typedef struct {
    int q; int mx; int r; int a; int g; bit term; int tag;
  } beat_t;

  typedef struct {
    int qs; bit sat; int qw; int tag;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 out_ready;
  logic signed [DW-1:0] q_in, max_q, reward;
  logic [SW-1:0]        alpha_sh, gamma_sh;
  logic                 terminal;
  logic [TW-1:0]        tag_in;

  logic                 in_ready_s, out_valid_s, sat_out_s;
  logic signed [DW-1:0] q_out_s;
  logic [TW-1:0]        tag_out_s;
  logic                 in_ready_w, out_valid_w, sat_out_w;
  logic signed [DW-1:0] q_out_w;
  logic [TW-1:0]        tag_out_w;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  q_update_pipe #(.DATA_W(DW), .SHIFT_W(SW), .TAG_W(TW), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .q_in(q_in), .max_q(max_q), .reward(reward), .alpha_sh(alpha_sh),
    .gamma_sh(gamma_sh), .terminal(terminal), .tag_in(tag_in),
    .out_valid(out_valid_s), .out_ready(out_ready), .q_out(q_out_s),
    .tag_out(tag_out_s), .sat_out(sat_out_s)
  );

  q_update_pipe #(.DATA_W(DW), .SHIFT_W(SW), .TAG_W(TW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .q_in(q_in), .max_q(max_q), .reward(reward), .alpha_sh(alpha_sh),
    .gamma_sh(gamma_sh), .terminal(terminal), .tag_in(tag_in),
    .out_valid(out_valid_w), .out_ready(out_ready), .q_out(q_out_w),
    .tag_out(tag_out_w), .sat_out(sat_out_w)
  );

  // Reference: floor(x / 2^s) by integer division, rounding toward -inf.
  function automatic int floor_pow2(input int x, input int s);
    int d;
    d = 1 << s;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic exp_t model(input beat_t b);
    exp_t e;
    int e1, td, e2, sum, m;
    e1  = b.term ? 0 : floor_pow2(b.mx, b.g);
    td  = b.r + e1 - b.q;
    e2  = floor_pow2(td, b.a);
    sum = b.q + e2;
    e.sat = 1'b0;
    e.qs  = sum;
    if (sum > int'(QMAX)) begin e.qs = int'(QMAX); e.sat = 1'b1; end
    if (sum < int'(QMIN)) begin e.qs = int'(QMIN); e.sat = 1'b1; end
    m = ((sum % 65536) + 65536) % 65536;
    e.qw  = (m >= 32768) ? m - 65536 : m;
    e.tag = b.tag;
    return e;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.q    = int'($signed(16'($urandom)));
    b.mx   = int'($signed(16'($urandom)));
    b.r    = int'($signed(16'($urandom)));
    b.a    = int'($urandom_range(0, 3));
    b.g    = int'($urandom_range(0, 3));
    b.term = ($urandom_range(0, 3) == 0);
    b.tag  = int'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic drive(input bit v, input beat_t b, input bit ordy);
    in_valid  = v;
    q_in      = 16'(b.q);
    max_q     = 16'(b.mx);
    reward    = 16'(b.r);
    alpha_sh  = 2'(b.a);
    gamma_sh  = 2'(b.g);
    terminal  = b.term;
    tag_in    = 8'(b.tag);
    out_ready = ordy;
  endtask

  task automatic drive_idle(input bit ordy);
    beat_t z;
    z = '{default: 0};
    drive(1'b0, z, ordy);
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (out_valid_s !== 1'b0 || q_out_s !== 16'sd0 || tag_out_s !== 8'd0 ||
        sat_out_s !== 1'b0 || in_ready_s !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: valid=%b q=%0d tag=%0d sat=%b rdy=%b, want 0 0 0 0 1",
               out_valid_s, q_out_s, tag_out_s, sat_out_s, in_ready_s);
    end
  endtask

  task automatic test_directed();
    beat_t b[5];
    int    xq[5], xw[5];
    bit    xs[5];
    b[0] = '{q:100,    mx:200,    r:50,     a:2, g:1, term:0, tag:8'h11}; xq[0] = 112;    xs[0] = 0; xw[0] = 112;
    b[1] = '{q:100,    mx:500,    r:-20,    a:1, g:3, term:1, tag:8'h22}; xq[1] = 40;     xs[1] = 0; xw[1] = 40;
    b[2] = '{q:32000,  mx:32767,  r:32767,  a:0, g:0, term:0, tag:8'h33}; xq[2] = 32767;  xs[2] = 1; xw[2] = -2;
    b[3] = '{q:0,      mx:0,      r:-7,     a:1, g:0, term:0, tag:8'h44}; xq[3] = -4;     xs[3] = 0; xw[3] = -4;
    b[4] = '{q:-32768, mx:-32768, r:-32768, a:0, g:0, term:0, tag:8'h55}; xq[4] = -32768; xs[4] = 1; xw[4] = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(1'b1, b[i], 1'b1);
      #1;
      n_cmp++;
      if (in_ready_s !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready_s);
      end
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        drive_idle(1'b1);
        n_cmp++;
        if (out_valid_s !== (c == 3)) begin
          n_err++; $display("FAIL dir%0d_latency: cycle %0d out_valid=%b want %b", i, c, out_valid_s, c == 3);
        end
        if (c == 3) begin
          n_cmp++;
          if (int'(q_out_s) !== xq[i] || sat_out_s !== xs[i] || int'(tag_out_s) !== b[i].tag ||
              int'(q_out_w) !== xw[i] || sat_out_w !== 1'b0) begin
            n_err++;
            $display("FAIL dir%0d_value: got q=%0d sat=%b tag=%0d qw=%0d satw=%b want q=%0d sat=%b tag=%0d qw=%0d satw=0",
                     i, q_out_s, sat_out_s, tag_out_s, q_out_w, sat_out_w, xq[i], xs[i], b[i].tag, xw[i]);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    beat_t bs[6];
    exp_t  e;
    int    idx = 0, cyc = 0, low_seen = 0;
    bit    exp_ir, held_prev = 1'b0;
    logic signed [DW-1:0] q_hold = '0;
    logic [TW-1:0]        t_hold = '0;
    for (int i = 0; i < 6; i++) bs[i] = rand_beat();
    while ((idx < 6 || sb.size() != 0) && cyc < 40) begin
      @(posedge clk); #1;
      if (idx < 6) drive(1'b1, bs[idx], cyc >= 5); else drive_idle(cyc >= 5);
      #1;
      exp_ir = !(sb.size() == 3 && !out_ready);
      n_cmp++;
      if (in_ready_s !== exp_ir) begin
        n_err++; $display("FAIL stall_in_ready: cycle %0d got %b want %b", cyc, in_ready_s, exp_ir);
      end
      if (!in_ready_s) low_seen++;
      if (held_prev) begin
        n_cmp++;
        if (out_valid_s !== 1'b1 || q_out_s !== q_hold || tag_out_s !== t_hold) begin
          n_err++; $display("FAIL stall_hold: got v=%b q=%0d tag=%0d want v=1 q=%0d tag=%0d",
                            out_valid_s, q_out_s, tag_out_s, q_hold, t_hold);
        end
      end
      if (out_valid_s) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL stall_spurious: got out_valid=1 want 0 (nothing pending)");
        end else begin
          e = sb[0];
          if (int'(q_out_s) !== e.qs || sat_out_s !== e.sat || int'(tag_out_s) !== e.tag ||
              int'(q_out_w) !== e.qw || sat_out_w !== 1'b0 || out_valid_w !== 1'b1) begin
            n_err++; $display("FAIL stall_result: got q=%0d sat=%b tag=%0d qw=%0d want q=%0d sat=%b tag=%0d qw=%0d",
                              q_out_s, sat_out_s, tag_out_s, q_out_w, e.qs, e.sat, e.tag, e.qw);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
      held_prev = out_valid_s && !out_ready;
      q_hold = q_out_s;
      t_hold = tag_out_s;
      if (in_valid && in_ready_s) begin sb.push_back(model(bs[idx])); idx++; end
      cyc++;
    end
    n_cmp++;
    if (idx != 6 || sb.size() != 0) begin
      n_err++; $display("FAIL stall_drain: accepted %0d pending %0d, want 6 and 0", idx, sb.size());
    end
    n_cmp++;
    if (low_seen != 2) begin
      n_err++; $display("FAIL stall_backpressure: in_ready low %0d cycles, want 2", low_seen);
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    exp_t  e;
    int    idx = 0, cyc = 0, emitted = 0, last_emit = -1;
    while ((idx < 20 || sb.size() != 0) && cyc < 60) begin
      @(posedge clk); #1;
      b = rand_beat();
      if (idx < 20) drive(1'b1, b, 1'b1); else drive_idle(1'b1);
      #1;
      n_cmp++;
      if (in_ready_s !== 1'b1) begin
        n_err++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", cyc, in_ready_s);
      end
      if (out_valid_s) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious: got out_valid=1 want 0 (nothing pending)");
        end else begin
          e = sb.pop_front();
          if (int'(q_out_s) !== e.qs || sat_out_s !== e.sat || int'(tag_out_s) !== e.tag ||
              int'(q_out_w) !== e.qw || sat_out_w !== 1'b0 || out_valid_w !== 1'b1) begin
            n_err++; $display("FAIL b2b_result: got q=%0d sat=%b tag=%0d qw=%0d want q=%0d sat=%b tag=%0d qw=%0d",
                              q_out_s, sat_out_s, tag_out_s, q_out_w, e.qs, e.sat, e.tag, e.qw);
          end
          emitted++;
          last_emit = cyc;
        end
      end
      if (in_valid && in_ready_s) begin sb.push_back(model(b)); idx++; end
      cyc++;
    end
    n_cmp++;
    if (emitted != 20 || last_emit != 22) begin
      n_err++; $display("FAIL b2b_throughput: emitted %0d last at cycle %0d, want 20 at 22", emitted, last_emit);
    end
  endtask

  task automatic test_random_flow();
    beat_t b;
    exp_t  e;
    int    sent = 0, cyc = 0;
    bit    v, r, exp_ir;
    while ((sent < 80 || sb.size() != 0) && cyc < 1000) begin
      @(posedge clk); #1;
      b = rand_beat();
      v = (sent < 80) && ($urandom_range(0, 9) < 7);
      r = (sent >= 80) || ($urandom_range(0, 9) < 6);
      drive(v, b, r);
      #1;
      exp_ir = !(sb.size() == 3 && !out_ready);
      n_cmp++;
      if (in_ready_s !== exp_ir) begin
        n_err++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", cyc, in_ready_s, exp_ir);
      end
      if (out_valid_s) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rand_spurious: got out_valid=1 want 0 (nothing pending)");
        end else begin
          e = sb[0];
          if (int'(q_out_s) !== e.qs || sat_out_s !== e.sat || int'(tag_out_s) !== e.tag ||
              int'(q_out_w) !== e.qw || sat_out_w !== 1'b0 || out_valid_w !== 1'b1) begin
            n_err++; $display("FAIL rand_result: got q=%0d sat=%b tag=%0d qw=%0d want q=%0d sat=%b tag=%0d qw=%0d",
                              q_out_s, sat_out_s, tag_out_s, q_out_w, e.qs, e.sat, e.tag, e.qw);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready_s) begin sb.push_back(model(b)); sent++; end
      cyc++;
    end
    n_cmp++;
    if (sent != 80 || sb.size() != 0) begin
      n_err++; $display("FAIL rand_drain: sent %0d pending %0d, want 80 and 0", sent, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    beat_t b;
    int    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      b = rand_beat();
      drive(1'b1, b, 1'b0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid_s !== 1'b1) begin
      n_err++; $display("FAIL rst_prefill: got out_valid=%b want 1", out_valid_s);
    end
    rst_n = 1'b0;
    drive_idle(1'b1);
    #1;
    n_cmp++;
    if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0 || q_out_s !== 16'sd0 || tag_out_s !== 8'd0) begin
      n_err++; $display("FAIL rst_async: got v=%b vw=%b q=%0d tag=%0d want 0 0 0 0",
                        out_valid_s, out_valid_w, q_out_s, tag_out_s);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (in_ready_s !== 1'b1) begin
      n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready_s);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive_idle(1'b1);
      if (out_valid_s !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL rst_stale: out_valid seen %0d cycles after reset, want 0", seen);
    end
    b = '{q:100, mx:200, r:50, a:2, g:1, term:0, tag:8'h5a};
    @(posedge clk); #1;
    drive(1'b1, b, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      drive_idle(1'b1);
    end
    n_cmp++;
    if (out_valid_s !== 1'b1 || q_out_s !== 16'sd112 || tag_out_s !== 8'h5a) begin
      n_err++; $display("FAIL rst_recover: got v=%b q=%0d tag=%0d want v=1 q=112 tag=90",
                        out_valid_s, q_out_s, tag_out_s);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random_flow();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
